// File: rtl/mdu_seq_if.sv
// Issue/result handshake bundle between the execute stage and the multiply/divide unit.
interface mdu_seq_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      funct3;
   logic [XLEN-1:0] s1;
   logic [XLEN-1:0] s2;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] d3;

   modport master (
      output in_valid, funct3, s1, s2, out_ready,
      input  in_ready, out_valid, d3
   );

   modport slave (
      input  in_valid, funct3, s1, s2, out_ready,
      output in_ready, out_valid, d3
   );
endinterface

// File: rtl/mdu_seq.sv
// Sequential RV32M multiply/divide: MUL_LAT-cycle multiply, XLEN+1-cycle restoring divide, 1-cycle special cases.
// One op in flight, result held until out_ready; MDU_SEQ_DIVREM_FUSE_EN reuses the last divide for a matching DIV/REM.
module mdu_seq #(
   parameter int XLEN    = 32,
   parameter int MUL_LAT = 2,
   localparam int CNT_W  = $clog2(XLEN+1)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   output logic       busy,
   mdu_seq_if.slave   io
);
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
   logic [XLEN-1:0]   quo_q, quo_d, rem_q, rem_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   d3_q, d3_d;
   logic              accept;

`ifdef MDU_SEQ_DIVREM_FUSE_EN
   logic              fuse_vld_q, fuse_vld_d;
   logic              fuse_sgn_q, fuse_sgn_d;
   logic [XLEN-1:0]   fuse_s1_q, fuse_s1_d, fuse_s2_q, fuse_s2_d;
   logic [XLEN-1:0]   fuse_quo_q, fuse_quo_d, fuse_rem_q, fuse_rem_d;
   logic              fuse_hit;
`endif

   function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
      return (sgn && x[XLEN-1]) ? -x : x;
   endfunction

   // Quotient and remainder arrive as magnitudes; restore signs for the requested op.
   function automatic logic [XLEN-1:0] fixup(input logic [XLEN-1:0] q, input logic [XLEN-1:0] r,
                                              input logic [2:0] f3, input logic [XLEN-1:0] x,
                                              input logic [XLEN-1:0] y);
      logic sgn;
      sgn = ~f3[0];
      if (f3[1]) return (sgn && x[XLEN-1]) ? -r : r;
      return (sgn && (x[XLEN-1] ^ y[XLEN-1])) ? -q : q;
   endfunction

   // Multiplier reads the live inputs in IDLE so that MUL_LAT=1 can complete on accept.
   logic [2:0]        mul_f3;
   logic [XLEN-1:0]   mul_x, mul_y, mul_res;
   logic [2*XLEN-1:0] mul_a, mul_b, mul_prod;
   logic              mul_xs, mul_ys;

   always_comb begin
      mul_f3   = (state_q == IDLE) ? io.funct3 : op_q;
      mul_x    = (state_q == IDLE) ? io.s1     : a_q;
      mul_y    = (state_q == IDLE) ? io.s2     : b_q;
      mul_xs   = ((mul_f3 == 3'b001) || (mul_f3 == 3'b010)) && mul_x[XLEN-1];
      mul_ys   = (mul_f3 == 3'b001) && mul_y[XLEN-1];
      mul_a    = {{XLEN{mul_xs}}, mul_x};
      mul_b    = {{XLEN{mul_ys}}, mul_y};
      mul_prod = mul_a * mul_b;
      mul_res  = (mul_f3 == 3'b000) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
   end

   logic [XLEN-1:0]   dvs, iter_quo, iter_rem;
   logic [XLEN:0]     shl, trial;
   logic              ge;

   always_comb begin
      dvs      = mag(b_q, ~op_q[0]);
      shl      = {rem_q, quo_q[XLEN-1]};
      trial    = shl - {1'b0, dvs};
      ge       = ~trial[XLEN];
      iter_rem = ge ? trial[XLEN-1:0] : shl[XLEN-1:0];
      iter_quo = {quo_q[XLEN-2:0], ge};
   end

   assign accept = io.in_valid && (state_q == IDLE) && !flush;

`ifdef MDU_SEQ_DIVREM_FUSE_EN
   assign fuse_hit = fuse_vld_q && (fuse_sgn_q == ~io.funct3[0]) &&
                     (fuse_s1_q == io.s1) && (fuse_s2_q == io.s2);
`endif

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      d3_d    = d3_q;
`ifdef MDU_SEQ_DIVREM_FUSE_EN
      fuse_vld_d = fuse_vld_q;
      fuse_sgn_d = fuse_sgn_q;
      fuse_s1_d  = fuse_s1_q;
      fuse_s2_d  = fuse_s2_q;
      fuse_quo_d = fuse_quo_q;
      fuse_rem_d = fuse_rem_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d = io.funct3;
               a_d  = io.s1;
               b_d  = io.s2;
               if (!io.funct3[2]) begin
                  if (MUL_LAT == 1) begin
                     state_d = DONE;
                     d3_d    = mul_res;
                  end else begin
                     state_d = MUL;
                     cnt_d   = CNT_W'(MUL_LAT - 1);
                  end
               end else if (io.s2 == '0) begin
                  state_d = DONE;
                  d3_d    = io.funct3[1] ? io.s1 : '1;
               end else if (!io.funct3[0] && (io.s1 == {1'b1, {(XLEN-1){1'b0}}}) && (io.s2 == '1)) begin
                  state_d = DONE;
                  d3_d    = io.funct3[1] ? '0 : io.s1;
`ifdef MDU_SEQ_DIVREM_FUSE_EN
               end else if (fuse_hit) begin
                  state_d = DONE;
                  d3_d    = fixup(fuse_quo_q, fuse_rem_q, io.funct3, io.s1, io.s2);
`endif
               end else begin
                  state_d = DIV;
                  cnt_d   = CNT_W'(XLEN);
                  quo_d   = mag(io.s1, ~io.funct3[0]);
                  rem_d   = '0;
               end
            end
         end
         MUL: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
               d3_d    = mul_res;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DIV: begin
            quo_d = iter_quo;
            rem_d = iter_rem;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
               d3_d    = fixup(iter_quo, iter_rem, op_q, a_q, b_q);
`ifdef MDU_SEQ_DIVREM_FUSE_EN
               fuse_vld_d = 1'b1;
               fuse_sgn_d = ~op_q[0];
               fuse_s1_d  = a_q;
               fuse_s2_d  = b_q;
               fuse_quo_d = iter_quo;
               fuse_rem_d = iter_rem;
`endif
            end
         end
         DONE: begin
            if (io.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d = IDLE;
`ifdef MDU_SEQ_DIVREM_FUSE_EN
         fuse_vld_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         d3_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         d3_q    <= d3_d;
      end
   end

`ifdef MDU_SEQ_DIVREM_FUSE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fuse_vld_q <= 1'b0;
         fuse_sgn_q <= 1'b0;
         fuse_s1_q  <= '0;
         fuse_s2_q  <= '0;
         fuse_quo_q <= '0;
         fuse_rem_q <= '0;
      end else begin
         fuse_vld_q <= fuse_vld_d;
         fuse_sgn_q <= fuse_sgn_d;
         fuse_s1_q  <= fuse_s1_d;
         fuse_s2_q  <= fuse_s2_d;
         fuse_quo_q <= fuse_quo_d;
         fuse_rem_q <= fuse_rem_d;
      end
   end
`endif

   assign busy         = (state_q != IDLE);
   assign io.in_ready  = (state_q == IDLE);
   assign io.out_valid = (state_q == DONE);
   assign io.d3        = d3_q;
endmodule

// File: tb/tb_mdu_seq.sv
// Directed-vector bench for mdu_seq at XLEN=32, MUL_LAT=2; latencies counted in clock edges from the accept edge.
module tb_mdu_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   logic busy;
   int   total = 0;
   int   bad = 0;

`ifdef MDU_SEQ_DIVREM_FUSE_EN
   localparam int FL = 1;
`else
   localparam int FL = 33;
`endif

   mdu_seq_if #(.XLEN(32)) bus ();
   mdu_seq #(.XLEN(32), .MUL_LAT(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .busy  (busy),
      .io    (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Issue one op, measure latency, check the result, optionally stall the consumer.
   task automatic run(input string tag, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int lat, input int hold);
      int n;
      logic [31:0] held;
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.funct3    = f3;
      bus.s1        = a;
      bus.s2        = b;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.funct3   = ~f3;
      bus.s1       = ~a;
      bus.s2       = b + 32'd3;
      n = 1;
      while (!bus.out_valid && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, ".lat"}, n, lat);
      check({tag, ".d3"}, bus.d3, exp);
      held = bus.d3;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({tag, ".hold_d3"}, bus.d3, held);
         check({tag, ".hold_rdy"}, {31'd0, bus.in_ready}, 32'd0);
         check({tag, ".hold_vld"}, {31'd0, bus.out_valid}, 32'd1);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.funct3    = 3'b000;
      bus.s1        = '0;
      bus.s2        = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst.d3", bus.d3, 32'd0);
      check("rst.busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run("mulh",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2, 0);
      run("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, 0);
      run("mul",    3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 2, 0);
      run("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 0);

      run("div_m7_2",  3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 0);
      run("rem_m7_2",  3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, FL, 0);
      run("div_7_m2",  3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33, 0);
      run("rem_7_m2",  3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, FL, 0);

      run("divu_z",   3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 0);
      run("remu_z",   3'b111, 32'd5, 32'd0, 32'd5, 1, 0);
      run("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
      run("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 0);

      run("divu_hold", 3'b101, 32'd100, 32'd7, 32'd14, 33, 5);

      // Abort a DIVU ten cycles in; the unit must be idle right after.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.funct3   = 3'b101;
      bus.s1       = 32'd50;
      bus.s2       = 32'd3;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      check("flush.pre_busy", {31'd0, busy}, 32'd1);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush.busy", {31'd0, busy}, 32'd0);
      check("flush.in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("flush.out_valid", {31'd0, bus.out_valid}, 32'd0);
      run("mul_3x4", 3'b000, 32'd3, 32'd4, 32'd12, 2, 0);

      // Accept presented together with flush in IDLE is dropped.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.funct3   = 3'b000;
      bus.s1       = 32'd6;
      bus.s2       = 32'd7;
      flush        = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      flush        = 1'b0;
      check("idleflush.busy", {31'd0, busy}, 32'd0);
      check("idleflush.in_ready", {31'd0, bus.in_ready}, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("idleflush.out_valid", {31'd0, bus.out_valid}, 32'd0);

      run("div_100_7",  3'b100, 32'd100, 32'd7, 32'd14, 33, 0);
      run("rem_100_7",  3'b110, 32'd100, 32'd7, 32'd2, FL, 0);
      run("rem_100_9",  3'b110, 32'd100, 32'd9, 32'd1, 33, 0);
      run("div_100_9",  3'b100, 32'd100, 32'd9, 32'd11, FL, 0);
      run("divu_100_9", 3'b101, 32'd100, 32'd9, 32'd11, 33, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
